// File: rtl/scan_chain_driver_if.sv
`timescale 1ns/1ps
// Command/response and chain-pin bundle between the wrapper controller, the driver and the scan chain.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; chain pins are unflowcontrolled.
interface scan_chain_driver_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CHAIN_LEN-1:0] cmd_pattern;
    logic                 cmd_capture;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;
    logic                 chain_si;
    logic                 chain_so;
    logic                 se;
    logic                 busy;

    // The driver itself: owns cmd_ready, the response and the chain control pins.
    modport master (
        input  cmd_valid,
        input  cmd_pattern,
        input  cmd_capture,
        input  rsp_ready,
        input  chain_so,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output chain_si,
        output se,
        output busy
    );

    // The surroundings: controller issues commands, chain returns serial data.
    modport slave (
        output cmd_valid,
        output cmd_pattern,
        output cmd_capture,
        output rsp_ready,
        output chain_so,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  chain_si,
        input  se,
        input  busy
    );
endinterface

// File: rtl/scan_chain_driver.sv
`timescale 1ns/1ps
// Serially loads a pattern into a scan chain, optionally captures once, unloads and returns the response.
// Latency: rsp_valid 2*CHAIN_LEN+1 cycles after accept, one more with a capture cycle.
// Backpressure: one command in flight; cmd_ready low until the response is consumed, response held while rsp_ready low.
module scan_chain_driver #(
    parameter int   CHAIN_LEN = 8,
    parameter logic FILL_BIT  = 1'b0
) (
    input  logic                   CLK,
    input  logic                   CoreIN_RESET,
    scan_chain_driver_if.master    bus
);

    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        RESP
    } stateT;

    stateT state;
    stateT nextState;

    logic [CNT_W-1:0]     bitCnt;
    logic [CHAIN_LEN-1:0] patReg;
    logic [CHAIN_LEN-1:0] patShifted;
    logic [CHAIN_LEN-1:0] rspReg;
    logic [CHAIN_LEN-1:0] rspShifted;
    logic                 captureReg;

    logic seReg;
    logic siReg;
    logic cmdReadyReg;
    logic rspValidReg;
    logic busyReg;

    logic seNext;
    logic siNext;
    logic cmdReadyNext;
    logic rspValidNext;
    logic busyNext;

    logic lastBit;
    logic accept;

    // Every chain-facing and handshake output comes straight from a flop.
    assign bus.se        = seReg;
    assign bus.chain_si  = siReg;
    assign bus.cmd_ready = cmdReadyReg;
    assign bus.rsp_valid = rspValidReg;
    assign bus.rsp_data  = rspReg;
    assign bus.busy      = busyReg;

    assign lastBit = (bitCnt == LAST_CNT);
    assign accept  = bus.cmd_valid && cmdReadyReg;

    // Pattern moves up one place per load cycle so the next bit to send is always the MSB;
    // unloaded bits enter at the LSB so the first bit out ends up in the MSB.
    always_comb begin
        patShifted    = patReg << 1;
        rspShifted    = rspReg << 1;
        rspShifted[0] = bus.chain_so;
    end

    // State register.
    always_ff @(posedge CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus the next value of each registered output.
    always_comb begin
        nextState    = state;
        seNext       = 1'b0;
        siNext       = FILL_BIT;
        cmdReadyNext = 1'b0;
        rspValidNext = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = LOAD;
                    seNext    = 1'b1;
                    siNext    = bus.cmd_pattern[CHAIN_LEN-1];
                end else begin
                    cmdReadyNext = 1'b1;
                end
            end
            LOAD: begin
                if (lastBit) begin
                    nextState = captureReg ? CAPTURE : UNLOAD;
                    seNext    = !captureReg;
                end else begin
                    seNext = 1'b1;
                    siNext = patShifted[CHAIN_LEN-1];
                end
            end
            CAPTURE: begin
                nextState = UNLOAD;
                seNext    = 1'b1;
            end
            UNLOAD: begin
                if (lastBit) begin
                    nextState    = RESP;
                    rspValidNext = 1'b1;
                end else begin
                    seNext = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    nextState    = IDLE;
                    cmdReadyNext = 1'b1;
                end else begin
                    rspValidNext = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        busyNext = (nextState != IDLE);
    end

    // Registered control outputs; reset values appear immediately on reset assertion.
    always_ff @(posedge CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            seReg       <= 1'b0;
            siReg       <= FILL_BIT;
            cmdReadyReg <= 1'b0;
            rspValidReg <= 1'b0;
            busyReg     <= 1'b0;
        end else begin
            seReg       <= seNext;
            siReg       <= siNext;
            cmdReadyReg <= cmdReadyNext;
            rspValidReg <= rspValidNext;
            busyReg     <= busyNext;
        end
    end

    // Shift counter: restarts on every state change, advances through LOAD and UNLOAD only.
    always_ff @(posedge CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            bitCnt <= '0;
        end else if (nextState != state) begin
            bitCnt <= '0;
        end else if (state == LOAD || state == UNLOAD) begin
            bitCnt <= bitCnt + 1'b1;
        end
    end

    // Pattern latch and load shift register; the capture flag is held for the whole operation.
    always_ff @(posedge CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            patReg     <= '0;
            captureReg <= 1'b0;
        end else if (state == IDLE && accept) begin
            patReg     <= bus.cmd_pattern;
            captureReg <= bus.cmd_capture;
        end else if (state == LOAD) begin
            patReg <= patShifted;
        end
    end

    // Response register: collects chain_so during UNLOAD and otherwise holds its last value.
    always_ff @(posedge CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            rspReg <= '0;
        end else if (state == UNLOAD) begin
            rspReg <= rspShifted;
        end
    end

endmodule

// File: tb/tb_scan_chain_driver.sv
`timescale 1ns/1ps
// Bench for scan_chain_driver: an 8-flop chain with a per-cycle reference model, plus a 1-flop build.
// Latency: checks the accept-to-response cycle counts with and without capture.
// Backpressure: holds rsp_ready low in RESP and offers a pending command meanwhile.
module tb_scan_chain_driver;

    localparam int   N    = 8;
    localparam logic FILL = 1'b0;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    scan_chain_driver_if #(.CHAIN_LEN(N)) bus8 ();
    scan_chain_driver_if #(.CHAIN_LEN(1)) bus1 ();

    scan_chain_driver #(.CHAIN_LEN(N), .FILL_BIT(FILL)) dut8 (
        .CLK          (CLK),
        .CoreIN_RESET (rst),
        .bus          (bus8)
    );

    scan_chain_driver #(.CHAIN_LEN(1), .FILL_BIT(FILL)) dut1 (
        .CLK          (CLK),
        .CoreIN_RESET (rst),
        .bus          (bus1)
    );

    // Scan chains: shift when se=1 (flop 0 takes chain_si), capture functional D=0 when se=0.
    logic [N-1:0] chain8;
    logic         chain1;
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            chain8 <= '0;
            chain1 <= 1'b0;
        end else begin
            chain8 <= bus8.se ? {chain8[N-2:0], bus8.chain_si} : '0;
            chain1 <= bus1.se ? bus1.chain_si : 1'b0;
        end
    end
    assign bus8.chain_so = chain8[N-1];
    assign bus1.chain_so = chain1;

    int passCnt  = 0;
    int totalCnt = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Per-cycle trace of the 8-flop chain pins, indexed by edges seen so far.
    logic seLog [0:4095];
    logic siLog [0:4095];
    always @(negedge CLK) begin
        if (cyc < 4096) begin
            seLog[cyc] <= bus8.se;
            siLog[cyc] <= bus8.chain_si;
        end
    end

    // Reference model: tracks only "cycles since accept" and what the chain must return.
    logic         mInOp, mResp, mReady, mCap;
    int           mAge;
    logic [N-1:0] mPat, mRsp;
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            mInOp  <= 1'b0;
            mResp  <= 1'b0;
            mReady <= 1'b0;
            mCap   <= 1'b0;
            mAge   <= 0;
            mPat   <= '0;
            mRsp   <= '0;
        end else if (mResp) begin
            if (bus8.rsp_ready) begin
                mResp  <= 1'b0;
                mReady <= 1'b1;
            end
        end else if (mInOp) begin
            if (mAge == 2 * N + int'(mCap)) begin
                mInOp <= 1'b0;
                mResp <= 1'b1;
                mRsp  <= mCap ? '0 : mPat;
            end else begin
                mAge <= mAge + 1;
            end
        end else if (mReady && bus8.cmd_valid) begin
            mInOp  <= 1'b1;
            mAge   <= 1;
            mReady <= 1'b0;
            mPat   <= bus8.cmd_pattern;
            mCap   <= bus8.cmd_capture;
        end else begin
            mReady <= 1'b1;
        end
    end

    function automatic logic expSe();
        return mInOp && !(mCap && mAge == N + 1);
    endfunction

    function automatic logic expSi();
        if (mInOp && mAge >= 1 && mAge <= N) return mPat[N - mAge];
        return FILL;
    endfunction

    // Cycle-by-cycle comparison of the 8-flop driver against the model.
    always @(negedge CLK) begin
        if (!rst) begin
            check("se", bus8.se, expSe());
            check("chain_si", bus8.chain_si, expSi());
            check("cmd_ready", bus8.cmd_ready, mReady);
            check("rsp_valid", bus8.rsp_valid, mResp);
            check("busy", bus8.busy, mInOp || mResp);
            if (!mInOp) check("rsp_data", bus8.rsp_data, mRsp);
        end
    end

    // Offer a command and return the edge count right after the accepting edge.
    task automatic issue(input logic [N-1:0] pat, input logic cap, output int t);
        int n;
        @(negedge CLK);
        bus8.cmd_valid   = 1'b1;
        bus8.cmd_pattern = pat;
        bus8.cmd_capture = cap;
        n = 0;
        while (!bus8.cmd_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("accept_ready", bus8.cmd_ready, 1'b1);
        @(negedge CLK);
        t = cyc;
        bus8.cmd_valid   = 1'b0;
        bus8.cmd_pattern = ~pat;
        bus8.cmd_capture = ~cap;
    endtask

    task automatic waitResp(output int tv);
        int n;
        n = 0;
        while (!bus8.rsp_valid && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("rsp_arrive", bus8.rsp_valid, 1'b1);
        tv = cyc;
    endtask

    task automatic handshake();
        bus8.rsp_ready = 1'b1;
        @(negedge CLK);
        bus8.rsp_ready = 1'b0;
    endtask

    task automatic txn(input string name, input logic [N-1:0] pat, input logic cap,
                       input logic [N-1:0] expData, input int expLat);
        int t, tv;
        issue(pat, cap, t);
        waitResp(tv);
        check({name, "_latency"}, tv - t + 1, expLat);
        check({name, "_data"}, bus8.rsp_data, expData);
        handshake();
    endtask

    // One-flop build: latency and data, plus the first load cycle's pins.
    task automatic txn1(input logic pat, input logic cap, input logic expData, input int expLat);
        int n, t;
        @(negedge CLK);
        bus1.cmd_valid   = 1'b1;
        bus1.cmd_pattern = pat;
        bus1.cmd_capture = cap;
        n = 0;
        while (!bus1.cmd_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("len1_ready", bus1.cmd_ready, 1'b1);
        @(negedge CLK);
        t = cyc;
        bus1.cmd_valid = 1'b0;
        check("len1_load_se", bus1.se, 1'b1);
        check("len1_load_si", bus1.chain_si, pat);
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("len1_rsp_arrive", bus1.rsp_valid, 1'b1);
        check("len1_latency", cyc - t + 1, expLat);
        check("len1_data", bus1.rsp_data, expData);
        bus1.rsp_ready = 1'b1;
        @(negedge CLK);
        bus1.rsp_ready = 1'b0;
        check("len1_idle_ready", bus1.cmd_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passCnt, totalCnt);
        $fatal(1);
    end

    initial begin
        int t, tv, ones;
        logic [7:0] siSeq;
        bus8.cmd_valid = 1'b0; bus8.cmd_pattern = '0; bus8.cmd_capture = 1'b0; bus8.rsp_ready = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_pattern = '0; bus1.cmd_capture = 1'b0; bus1.rsp_ready = 1'b0;

        // Reset values while reset is held across an edge.
        #12;
        check("rst_cmd_ready", bus8.cmd_ready, 1'b0);
        check("rst_se", bus8.se, 1'b0);
        check("rst_si", bus8.chain_si, FILL);
        check("rst_busy", bus8.busy, 1'b0);
        check("rst_rsp_valid", bus8.rsp_valid, 1'b0);
        check("rst_rsp_data", bus8.rsp_data, 8'h00);
        check("rst1_cmd_ready", bus1.cmd_ready, 1'b0);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        check("release_ready_low", bus8.cmd_ready, 1'b0);
        @(negedge CLK);
        check("first_edge_ready", bus8.cmd_ready, 1'b1);
        check("first_edge_ready1", bus1.cmd_ready, 1'b1);

        // Loopback A5: MSB-first chain_si, 16 shift cycles, response at T+17.
        issue(8'hA5, 1'b0, t);
        waitResp(tv);
        check("lb_latency", tv - t + 1, 17);
        check("lb_data", bus8.rsp_data, 8'hA5);
        siSeq = 8'b1010_0101;
        for (int i = 0; i < 8; i++) check("lb_si_seq", siLog[t + i], siSeq[7 - i]);
        ones = 0;
        for (int i = 0; i < 16; i++) ones += int'(seLog[t + i]);
        check("lb_se_cycles", ones, 16);
        check("lb_se_resp", seLog[t + 16], 1'b0);
        handshake();

        // Capture 3C: se low exactly at T+9, response at T+18, chain D=0 returns zero.
        issue(8'h3C, 1'b1, t);
        waitResp(tv);
        check("cap_latency", tv - t + 1, 18);
        check("cap_data", bus8.rsp_data, 8'h00);
        check("cap_se_t8", seLog[t + 7], 1'b1);
        check("cap_se_t9", seLog[t + 8], 1'b0);
        check("cap_se_t10", seLog[t + 9], 1'b1);
        ones = 0;
        for (int i = 0; i < 17; i++) ones += int'(seLog[t + i]);
        check("cap_se_cycles", ones, 16);
        handshake();

        // Backpressure: response held 5 cycles with a command pending, then accepted right after.
        issue(8'hA5, 1'b0, t);
        waitResp(tv);
        bus8.cmd_valid   = 1'b1;
        bus8.cmd_pattern = 8'h5A;
        bus8.cmd_capture = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", bus8.rsp_valid, 1'b1);
            check("bp_rsp_data", bus8.rsp_data, 8'hA5);
            check("bp_cmd_ready", bus8.cmd_ready, 1'b0);
            @(negedge CLK);
        end
        bus8.rsp_ready = 1'b1;
        @(negedge CLK);
        bus8.rsp_ready = 1'b0;
        check("bp_valid_drop", bus8.rsp_valid, 1'b0);
        check("bp_data_hold", bus8.rsp_data, 8'hA5);
        check("bp_idle_ready", bus8.cmd_ready, 1'b1);
        @(negedge CLK);
        t = cyc;
        bus8.cmd_valid   = 1'b0;
        bus8.cmd_pattern = 8'h00;
        check("bp_accepted", bus8.busy, 1'b1);
        waitResp(tv);
        check("bp2_latency", tv - t + 1, 17);
        check("bp2_data", bus8.rsp_data, 8'h5A);
        handshake();

        // Back-to-back loopbacks keep order and bits.
        txn("b2b_ff", 8'hFF, 1'b0, 8'hFF, 17);
        txn("b2b_01", 8'h01, 1'b0, 8'h01, 17);

        // Reset during LOAD at T+4 aborts at once; the next command still works.
        issue(8'hC3, 1'b0, t);
        repeat (3) @(negedge CLK);
        check("mid_se_before", bus8.se, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_se", bus8.se, 1'b0);
        check("mid_rst_busy", bus8.busy, 1'b0);
        check("mid_rst_rsp_valid", bus8.rsp_valid, 1'b0);
        check("mid_rst_cmd_ready", bus8.cmd_ready, 1'b0);
        check("mid_rst_si", bus8.chain_si, FILL);
        @(negedge CLK);
        rst = 1'b0;
        repeat (2) @(negedge CLK);
        txn("after_rst", 8'h5A, 1'b0, 8'h5A, 17);

        // One-flop chain: loopback at T+3, capture at T+4.
        txn1(1'b1, 1'b0, 1'b1, 3);
        txn1(1'b1, 1'b1, 1'b0, 4);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/scan_chain_driver.md
Name: scan_chain_driver

Overview:
- Initiator for an IEEE 1500 core data register (CDR) scan chain of scan flip-flops.
- Accepts a parallel test pattern, serially loads it into the chain with se=1, and optionally pulses one capture cycle with se=0.
- Then serially unloads the chain and returns the unloaded bits as a parallel response word.
- Sits between the wrapper test controller and the chain's serial input, serial output and se pins; it shares the chain's clock and reset.

Parameters:
CHAIN_LEN, 8, number of flops in the driven chain (>=1)
FILL_BIT, 1'b0, value driven on chain_si during unload and idle

Ports:
CLK  input  1  clock, rising-edge; same clock as the chain
CoreIN_RESET  input  1  asynchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at a rising edge
cmd_pattern  input  CHAIN_LEN  pattern; bit k lands in chain flop k (flop 0 nearest serial input)
cmd_capture  input  1  1 = insert one capture cycle between load and unload
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready at a rising edge
rsp_data  output  CHAIN_LEN  unloaded chain contents; bit k = flop k before unload
chain_si  output  1  drives chain ScanChainIN
chain_so  input  1  from chain ScanChainOut (last flop)
se  output  1  drives chain scan-enable
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous. While CoreIN_RESET is high: state=IDLE, se=0, chain_si=FILL_BIT, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, counter=0.
- cmd_ready rises on the first clock edge after reset release.
- se, chain_si, cmd_ready, rsp_valid and busy are all registered outputs; none is driven combinationally from inputs.
- Shift counter is clog2(CHAIN_LEN) bits (minimum 1 bit). It counts 0..CHAIN_LEN-1 and clears on every state change.
- Command accepted at edge T; pattern is latched into a shift register.
- IDLE: se=0, chain_si=FILL_BIT, cmd_ready=1. Accepting a command moves to LOAD.
- LOAD: cycles T+1..T+CHAIN_LEN, with se=1.
  - chain_si in load cycle i = pattern[CHAIN_LEN-1-i], MSB first.
  - After the last cycle, the next state is CAPTURE if cmd_capture was 1, else UNLOAD.
- CAPTURE: exactly one cycle with se=0 and chain_si=FILL_BIT. The chain loads its functional D inputs. Next state is UNLOAD.
- UNLOAD: CHAIN_LEN cycles with se=1 and chain_si=FILL_BIT.
  - At the rising edge ending unload cycle i, sample chain_so into rsp_data[CHAIN_LEN-1-i].
  - Next state is RESP.
- RESP: rsp_valid=1, rsp_data stable, se=0, cmd_ready=0.
  - When rsp_valid&&rsp_ready, go to IDLE; rsp_valid drops the next cycle and rsp_data holds its value.
- Latency from accept edge T to rsp_valid high:
  - without capture: cycle T+2*CHAIN_LEN+1
  - with capture: cycle T+2*CHAIN_LEN+2
- Throughput: the earliest next accept is 1 cycle after response handshake (IDLE re-asserts cmd_ready).
- No command overlap: cmd_ready=0 in LOAD, CAPTURE, UNLOAD and RESP. A cmd_valid arriving there is ignored, and cmd_pattern is not re-sampled.
- rsp_ready while not in RESP is ignored.
- Simultaneous events: rsp_ready held high completes the handshake on the first RESP cycle.
- Reset asserted mid-operation: immediate abort to IDLE with the reset values above. No response is produced, and the chain contents are not preserved.
- CHAIN_LEN=1 boundary: LOAD and UNLOAD are each one cycle; the counter never increments.
- cmd_capture=0 is a loopback: rsp_data equals cmd_pattern for a healthy chain.

Test Plan:
- Chain model: 8 scan flops, functional D=0, shared CLK/CoreIN_RESET.
- Loopback: accept 8'hA5 with cmd_capture=0 at T. Required: se=1 in T+1..T+16; chain_si in T+1..T+8 = 1,0,1,0,0,1,0,1; rsp_valid at T+17; rsp_data=8'hA5.
- Capture: accept 8'h3C with cmd_capture=1. Required: se=0 exactly at T+9; rsp_valid at T+18; rsp_data=8'h00.
- Backpressure: rsp_ready low 5 cycles in RESP. Required: rsp_valid and rsp_data=8'hA5 held, cmd_ready=0, a pending cmd_valid not accepted. When rsp_ready goes high, IDLE follows and the command is accepted on the next edge.
- Back-to-back: 8'hFF then 8'h01, both loopback. Required: responses 8'hFF then 8'h01, in order; no lost or duplicated bits.
- Reset mid-LOAD: assert CoreIN_RESET at T+4. Required: se=0, busy=0, rsp_valid=0 asynchronously, before the next edge. A subsequent 8'h5A loopback returns 8'h5A.
- CHAIN_LEN=1 build: pattern 1'b1 loopback. Required: rsp_valid at T+3, rsp_data=1.
